imem_arbiter: RTL
=================

# imem_arbiter

Arbiter that shares the single 64×32 instruction memory between the core's fetch port and the program-loader port. Fetch has priority; a starvation counter guarantees the loader a slot. The block drives the memory's address, write-enable and write-data, captures read data, and routes each read response back to the port that issued it. It sits between the fetch stage, the loader and the instruction memory.

## Interface
- ADDR_W, 6, word address width (64 words)
- DATA_W, 32, instruction width
- STARVE_LIMIT, 4, consecutive refused loader cycles before the loader is forced a grant (≥1)

Ports:
- CLK  in  1  system clock; all registers on posedge
- RST_N  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch read request
- fetch_addr  in  ADDR_W  fetch word address
- fetch_kill  in  1  cancel the fetch response due next cycle (redirect)
- fetch_gnt  out  1  fetch request accepted this cycle
- fetch_rvalid  out  1  fetch_rdata valid
- fetch_rdata  out  DATA_W  registered read data for fetch
- load_req  in  1  loader request
- load_we  in  1  1 = write, 0 = read
- load_addr  in  ADDR_W  loader word address
- load_wdata  in  DATA_W  loader write data
- load_gnt  out  1  loader request accepted this cycle
- load_rvalid  out  1  load_rdata valid (reads only)
- load_rdata  out  DATA_W  registered read data for loader
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, updated on negedge CLK

## Operation
- Each cycle at most one grant. Decision is combinational from current requests and the starvation counter.
- Default: fetch_req wins; load_gnt = load_req & ~fetch_req.
- starve_cnt increments when load_req=1 and load_gnt=0, saturating at STARVE_LIMIT. It clears on load_gnt or when load_req=0.
- starve_cnt == STARVE_LIMIT with load_req=1: loader wins even if fetch_req=1, and fetch_gnt=0.
- Granted requester drives mem_addr. mem_we = load_gnt & load_we, and mem_wdata = load_wdata.
- No grant: mem_addr holds its last registered value and mem_we=0.
- Response owner register:
  - Values: NONE, FETCH or LOAD.
  - Set at posedge from the read grant of the ending cycle; loader writes set NONE.
- Read data capture: at posedge after a read grant, the owner's rdata register loads mem_rdata. The matching rvalid is high for exactly that following cycle.
- The other port's rdata register holds its value.
- fetch_kill high in the grant cycle: fetch_rvalid is suppressed next cycle. fetch_rdata may still update.
- fetch_kill has no effect on loader responses.
- Requests are not queued. A refused requester must hold req and address until it sees its gnt.

## Timing
- Reset (RST_N=0, asynchronous):
  - fetch_rvalid=0, load_rvalid=0.
  - fetch_rdata=0, load_rdata=0.
  - starve_cnt=0, owner=NONE.
  - Registered mem_addr=0.
- Grants assert in the cycle the request is present.
- Read latency is 1. Grant in cycle N → rvalid and data in cycle N+1.
- Memory samples mem_addr on negedge of cycle N. The arbiter captures mem_rdata at posedge N+1.
- Back-to-back grants sustain one access per cycle.
- Loader write in cycle N updates the memory at negedge N.
- Fetch of the same address in cycle N+1 returns the new word in N+2.
- Reset asserted between grant and capture drops the pending response; no rvalid after release.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: fetch granted. With starve_cnt == STARVE_LIMIT: loader granted.
- Worst-case loader wait is STARVE_LIMIT cycles.

## Structure
- Shared package holds:
  - ADDR_W and DATA_W constants.
  - Owner enum {OWN_NONE, OWN_FETCH, OWN_LOAD}.
- One sub-module, imem_starve_ctr, holds the saturating counter and the force-loader flag.
- The rest is flat: grant logic, owner register, two capture registers.

## Test plan
- Fetch only:
  - Stimulus: fetch_req=1 with addresses 0,1,2 on consecutive cycles; memory preloaded with word = 0x1000_0000+addr.
  - Required: fetch_gnt high 3 cycles; fetch_rvalid in cycles 2–4 with 0x1000_0000, 0x1000_0001, 0x1000_0002.
- Loader write then fetch:
  - Stimulus: loader writes 0xDEADBEEF to addr 5; fetch of addr 5 next cycle.
  - Required: fetch_rdata=0xDEADBEEF; load_rvalid never asserted.
- Starvation:
  - Stimulus: fetch_req held high; load_req high from cycle 0.
  - Required: load_gnt first in cycle 4 with STARVE_LIMIT=4; fetch_gnt low in that cycle, high again in cycle 5.
- Kill:
  - Stimulus: fetch of addr 3 with fetch_kill=1 in the grant cycle.
  - Required: fetch_rvalid stays 0; a following unkilled fetch of addr 4 returns rvalid normally.
- Reset mid-operation:
  - Stimulus: read granted; RST_N pulled low before the next posedge.
  - Required: all rvalids 0, both rdata 0, starve_cnt 0, no response after release.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
package imem_arbiter_pkg;

  localparam int ADDR_W = 6;   // 64-word instruction memory
  localparam int DATA_W = 32;  // instruction width

  // Which port the read response in flight belongs to.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  // Owner of the response produced by this cycle's grant.
  // Loader writes produce no response.
  function automatic owner_e next_owner(input logic fetch_gnt,
                                        input logic load_gnt,
                                        input logic load_we);
    if (fetch_gnt)               return OWN_FETCH;
    else if (load_gnt && !load_we) return OWN_LOAD;
    else                         return OWN_NONE;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between fetch stage, program loader, instruction memory
// and the arbiter. master = requesters + memory, slave = arbiter.
interface imem_arbiter_if;
  import imem_arbiter_pkg::*;

  // fetch port
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_kill;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;

  // loader port
  logic              load_req;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_wdata;
  logic              load_gnt;
  logic              load_rvalid;
  logic [DATA_W-1:0] load_rdata;

  // memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output fetch_req, fetch_addr, fetch_kill,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    output load_req, load_we, load_addr, load_wdata,
    input  load_gnt, load_rvalid, load_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  fetch_req, fetch_addr, fetch_kill,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    input  load_req, load_we, load_addr, load_wdata,
    output load_gnt, load_rvalid, load_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive refused loader cycles; raises
// force_load once the loader has waited LIMIT cycles.
module imem_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic load_req,
  input  logic load_gnt,
  output logic force_load
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  // Count refusals; any grant or dropped request restarts the wait.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                    cnt <= '0;
    else if (!load_req || load_gnt) cnt <= '0;
    else if (cnt != LIM)           cnt <= cnt + CW'(1);
  end

  assign force_load = load_req && (cnt == LIM);

endmodule

// File: rtl/imem_arbiter.sv
// Shares one 64x32 instruction memory between fetch and the program
// loader. Fetch wins by default; the loader is forced through after
// STARVE_LIMIT refused cycles. Read responses come back one cycle
// after the grant on the port that issued them.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  imem_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("imem_arbiter: STARVE_LIMIT must be >= 1");
  end

  logic              force_load;
  logic              fetch_gnt;
  logic              load_gnt;
  logic              load_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] addr_q;
  owner_e            owner_q;
  logic              kill_q;
  logic [DATA_W-1:0] fetch_rdata_q;
  logic [DATA_W-1:0] load_rdata_q;

  imem_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load_req   (bus.load_req),
    .load_gnt   (load_gnt),
    .force_load (force_load)
  );

  // Single grant per cycle: fetch first unless the loader is starved.
  always_comb begin
    fetch_gnt = bus.fetch_req & ~force_load;
    load_gnt  = bus.load_req & (force_load | ~bus.fetch_req);
    load_rd   = load_gnt & ~bus.load_we;
  end

  // Address mux; idle cycles keep presenting the last granted address.
  always_comb begin
    mem_addr = addr_q;
    if (load_gnt)       mem_addr = bus.load_addr;
    else if (fetch_gnt) mem_addr = bus.fetch_addr;
  end

  // Remember the last granted address for idle cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                     addr_q <= '0;
    else if (fetch_gnt || load_gnt) addr_q <= mem_addr;
  end

  // Response owner and kill flag for the access ending this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_q <= OWN_NONE;
      kill_q  <= 1'b0;
    end else begin
      owner_q <= next_owner(fetch_gnt, load_gnt, bus.load_we);
      kill_q  <= fetch_gnt & bus.fetch_kill;
    end
  end

  // Capture memory data into the issuing port's register; the other
  // port's register holds. Killed fetches still capture, only rvalid
  // is suppressed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_rdata_q <= '0;
      load_rdata_q  <= '0;
    end else begin
      if (fetch_gnt) fetch_rdata_q <= bus.mem_rdata;
      if (load_rd)   load_rdata_q  <= bus.mem_rdata;
    end
  end

  assign bus.fetch_gnt    = fetch_gnt;
  assign bus.load_gnt     = load_gnt;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_we       = load_gnt & bus.load_we;
  assign bus.mem_wdata    = bus.load_wdata;
  assign bus.fetch_rvalid = (owner_q == OWN_FETCH) & ~kill_q;
  assign bus.fetch_rdata  = fetch_rdata_q;
  assign bus.load_rvalid  = (owner_q == OWN_LOAD);
  assign bus.load_rdata   = load_rdata_q;

endmodule
